apb_master_arb: RTL and testbench



---
 rtl/apb_master_arb_pkg.sv | 24 ++
 rtl/apb_rr_arb2.sv | 29 ++
 rtl/apb_master_arb.sv | 165 ++++++++++++++++
 tb/tb_apb_master_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_master_arb_pkg
// Shared types and constants for the two-requester APB master arbiter.
//   apb_state_e   : phase FSM encoding (IDLE/SETUP/ACCESS)
//   NUM_REQ       : number of requesters sharing the APB master port
//   RSP_ZERO_DATA : read data returned on writes and forced completions
//   idx2oh        : requester index -> one-hot vector
// -----------------------------------------------------------------------------
package apb_master_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int          NUM_REQ       = 2;
  localparam logic [31:0] RSP_ZERO_DATA = 32'h0;

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// -----------------------------------------------------------------------------
// apb_rr_arb2
// Combinational 2-way round-robin grant.
//   req_i      : request vector, bit i = requester i
//   en_i       : grant allowed this cycle (arbiter idle, not in reset)
//   rr_ptr_i   : requester favoured when both request
//   gnt_o      : one-hot grant (all zero when disabled or no request)
//   gnt_idx_o  : index of the selected requester
//   rr_ptr_d_o : next pointer value; moves to the other requester on a grant
// -----------------------------------------------------------------------------
module apb_rr_arb2
  import apb_master_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_idx_o,
  output logic               rr_ptr_d_o
);

  always_comb begin
    // A lone requester wins outright; a tie goes to the pointer.
    gnt_idx_o  = (req_i == 2'b11) ? rr_ptr_i : req_i[1];
    gnt_o      = (en_i && (|req_i)) ? idx2oh(gnt_idx_o) : '0;
    rr_ptr_d_o = (|gnt_o) ? ~gnt_idx_o : rr_ptr_i;
  end

endmodule

// File: rtl/apb_master_arb.sv
// -----------------------------------------------------------------------------
// apb_master_arb
// Shares one APB master port between two requesters with round-robin grant
// per transfer, and sequences the SETUP/ACCESS phases. Address decode and
// psel fan-out stay in the downstream bridge.
//
// Ports
//   pclk, prst              : clock, synchronous active-high reset
//   req_vld/addr/write/wdata: per-requester request (slice i = requester i)
//   req_rdy                 : one-hot accept pulse, combinational in IDLE
//   rsp_vld/rdata/err       : one-hot completion pulse with data and error
//   paddr/psel/penable/
//   pwrite/pwdata           : APB master outputs (all registered)
//   prdata/pready/pslverr   : APB slave returns
//   busy                    : transfer in progress (state != IDLE)
//
// Optional build macro APB_MASTER_ARB_TIMEOUT_EN: ACCESS is abandoned with
// rsp_err=1 once the wait counter reaches TO_CYC while pready stays low.
// Without it ACCESS waits for pready indefinitely.
// -----------------------------------------------------------------------------
module apb_master_arb
  import apb_master_arb_pkg::*;
#(
  parameter int              ADDR_W = 40,
  parameter int              DATA_W = 32,
  parameter int              TO_W   = 8,
  parameter logic [TO_W-1:0] TO_CYC = 8'd255
) (
  input  logic                           pclk,
  input  logic                           prst,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             req_rdy,
  output logic [NUM_REQ-1:0]             rsp_vld,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_W-1:0]              paddr,
  output logic                           psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [DATA_W-1:0]              pwdata,
  input  logic [DATA_W-1:0]              prdata,
  input  logic                           pready,
  input  logic                           pslverr,
  output logic                           busy
);

  apb_state_e          state_q;
  logic                rr_ptr_q, rr_ptr_d;
  logic                gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0]  gnt;
  logic                arb_en;

  logic [ADDR_W-1:0]   paddr_q;
  logic                psel_q, penable_q, pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [NUM_REQ-1:0]  rsp_vld_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

`ifdef APB_MASTER_ARB_TIMEOUT_EN
  logic [TO_W-1:0]     to_cnt_q;
`else
  logic                unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
`endif

  // Grants only happen in IDLE and never while reset is held, so req_rdy
  // is forced low during prst even though it is combinational.
  assign arb_en = (state_q == IDLE) && !prst;

  apb_rr_arb2 u_arb (
    .req_i      (req_vld),
    .en_i       (arb_en),
    .rr_ptr_i   (rr_ptr_q),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx_d),
    .rr_ptr_d_o (rr_ptr_d)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      gnt_idx_q   <= 1'b0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_vld_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      // rsp_vld is a single-cycle pulse on the cycle after completion.
      rsp_vld_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            state_q   <= SETUP;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            paddr_q   <= req_addr[gnt_idx_d];
            pwrite_q  <= req_write[gnt_idx_d];
            pwdata_q  <= req_wdata[gnt_idx_d];
            psel_q    <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
          to_cnt_q  <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_vld_q   <= idx2oh(gnt_idx_q);
            rsp_rdata_q <= pwrite_q ? DATA_W'(RSP_ZERO_DATA) : prdata;
            rsp_err_q   <= pslverr;
          end
`ifdef APB_MASTER_ARB_TIMEOUT_EN
          // pready in the match cycle takes the branch above, so a late
          // slave still completes normally.
          else if (to_cnt_q == TO_CYC) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_vld_q   <= idx2oh(gnt_idx_q);
            rsp_rdata_q <= DATA_W'(RSP_ZERO_DATA);
            rsp_err_q   <= 1'b1;
          end else if (to_cnt_q != '1) begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy   = gnt;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_arb.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arb
// Directed protocol steps followed by a randomized phase in which the bench
// plays both requesters and the APB slave, predicting grants and responses
// from the arbitration and completion rules.
// -----------------------------------------------------------------------------
module tb_apb_master_arb;

`ifdef APB_MASTER_ARB_TIMEOUT_EN
  localparam logic [7:0] TB_TO_CYC = 8'd4;
`else
  localparam logic [7:0] TB_TO_CYC = 8'd255;
`endif

  logic             pclk, prst;
  logic [1:0]       req_vld, req_write, req_rdy, rsp_vld;
  logic [1:0][39:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [31:0]      rsp_rdata, pwdata, prdata;
  logic             rsp_err, psel, penable, pwrite, pready, pslverr, busy;
  logic [39:0]      paddr;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_arb #(.ADDR_W(40), .DATA_W(32), .TO_W(8), .TO_CYC(TB_TO_CYC)) dut (
    .pclk(pclk), .prst(prst), .req_vld(req_vld), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are sampled 2 time units after the active edge.
  task automatic step();
    @(posedge pclk);
    #2;
  endtask

  // reference-model state for the randomized phase
  typedef struct {
    logic        req;
    logic [39:0] addr;
    logic        write;
    logic [31:0] wdata;
  } txn_t;

  initial begin
    txn_t        cur;
    logic [1:0]  act;
    logic        m_busy, m_pref, m_due, m_err, g;
    int          m_k;
    logic [1:0]  m_oh, exp_rdy;
    logic [31:0] m_rdata;

    prst = 1'b1; req_vld = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step(); step();

    // ---------------- reset state ----------------
    req_vld = 2'b11; #1;
    check("rst_rdy", req_rdy, 2'b00);
    check("rst_psel_pen", {psel, penable, pwrite}, 3'b000);
    check("rst_paddr", paddr, 40'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rsp", {rsp_vld, rsp_err}, 3'b000);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    req_vld = 2'b00;
    prst = 1'b0;

    // ---------------- round robin, both writing ----------------
    req_vld = 2'b11; req_write = 2'b11;
    req_addr[0] = 40'h100; req_addr[1] = 40'h200;
    req_wdata[0] = 32'h11; req_wdata[1] = 32'h22;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy", req_rdy, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) check("rr_rsp", rsp_vld, (i % 2) ? 2'b01 : 2'b10);
      step();
      check("rr_setup", {psel, penable}, 2'b10);
      check("rr_pwdata", pwdata, (i % 2) ? 32'h22 : 32'h11);
      step();
      check("rr_access", {psel, penable}, 2'b11);
      step();
    end
    req_vld = 2'b00; #1;
    check("rr_last_rsp", rsp_vld, 2'b10);
    check("rr_no_rdy", req_rdy, 2'b00);
    pready = 1'b0;

    // ---------------- single zero-wait read ----------------
    req_vld = 2'b01; req_write = 2'b00; req_addr[0] = 40'h10015000; #1;
    check("rd_rdy", req_rdy, 2'b01);
    step(); req_vld = 2'b00;
    check("rd_setup", {psel, penable, pwrite, busy}, 4'b1001);
    check("rd_paddr", paddr, 40'h10015000);
    step();
    check("rd_access", {psel, penable}, 2'b11);
    pready = 1'b1; prdata = 32'hA5A5_0001;
    step();
    check("rd_rsp", rsp_vld, 2'b01);
    check("rd_rdata", rsp_rdata, 32'hA5A5_0001);
    check("rd_err", {rsp_err, psel, penable}, 3'b000);
    pready = 1'b0;

    // ---------------- write, 3 wait states, slave error ----------------
    req_vld = 2'b10; req_write = 2'b10; req_addr[1] = 40'h10020004;
    req_wdata[1] = 32'hDEADBEEF; #1;
    check("ws_rdy", req_rdy, 2'b10);
    step(); req_vld = 2'b00;
    step();
    for (int k = 0; k < 4; k++) begin
      check("ws_pen", {psel, penable}, 2'b11);
      check("ws_paddr", paddr, 40'h10020004);
      check("ws_pwdata", pwdata, 32'hDEADBEEF);
      check("ws_norsp", rsp_vld, 2'b00);
      if (k == 3) begin pready = 1'b1; pslverr = 1'b1; prdata = 32'h1234; end
      step();
    end
    check("ws_rsp", rsp_vld, 2'b10);
    check("ws_err", rsp_err, 1'b1);
    check("ws_rdata", rsp_rdata, 32'h0);
    pready = 1'b0; pslverr = 1'b0;

    // ---------------- withdrawn request during SETUP ----------------
    req_vld = 2'b01; req_write = 2'b00; req_addr[0] = 40'h3000; #1;
    check("wd_rdy0", req_rdy, 2'b01);
    step();
    req_vld = 2'b10; req_addr[1] = 40'h3100; #1;
    check("wd_rdy_setup", req_rdy, 2'b00);
    step(); req_vld = 2'b00;
    pready = 1'b1; prdata = 32'h77;
    step(); pready = 1'b0;
    check("wd_rsp", rsp_vld, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step();
      check("wd_idle", {psel, busy, rsp_vld}, 4'b0000);
    end

    // ---------------- reset mid-ACCESS ----------------
    req_vld = 2'b01; req_addr[0] = 40'h4000; #1;
    check("ra_rdy", req_rdy, 2'b01);
    step(); req_vld = 2'b00;
    step();
    check("ra_access", {psel, penable}, 2'b11);
    prst = 1'b1;
    step(); prst = 1'b0;
    check("ra_drop", {psel, penable, busy, rsp_vld}, 5'b00000);
    step();
    check("ra_norsp", {rsp_vld, psel}, 3'b000);
    req_vld = 2'b10; req_write = 2'b00; req_addr[1] = 40'h4100; #1;
    check("ra_new_rdy", req_rdy, 2'b10);
    step(); req_vld = 2'b00;
    check("ra_new_paddr", paddr, 40'h4100);
    step(); pready = 1'b1; prdata = 32'h99;
    step(); pready = 1'b0;
    check("ra_new_rsp", rsp_vld, 2'b10);
    check("ra_new_rdata", rsp_rdata, 32'h99);

`ifdef APB_MASTER_ARB_TIMEOUT_EN
    // ---------------- timeout: forced completion ----------------
    req_vld = 2'b01; req_addr[0] = 40'h5000; #1;
    check("to_rdy", req_rdy, 2'b01);
    step(); req_vld = 2'b00;
    step();
    for (int k = 0; k < int'(TB_TO_CYC); k++) begin
      check("to_wait", {psel, penable, rsp_vld}, 4'b1100);
      step();
    end
    check("to_match_cycle", {psel, penable}, 2'b11);
    step();
    check("to_rsp", rsp_vld, 2'b01);
    check("to_err", {rsp_err, psel, penable}, 3'b100);
    check("to_rdata", rsp_rdata, 32'h0);
    // pready exactly in the match cycle completes normally
    req_vld = 2'b01; #1;
    step(); req_vld = 2'b00;
    step();
    for (int k = 0; k < int'(TB_TO_CYC); k++) step();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h55;
    step(); pready = 1'b0;
    check("to_late_rsp", rsp_vld, 2'b01);
    check("to_late_err", rsp_err, 1'b0);
    check("to_late_rdata", rsp_rdata, 32'h55);
`else
    // ---------------- no timeout: long wait keeps ACCESS ----------------
    req_vld = 2'b01; req_addr[0] = 40'h5000; #1;
    step(); req_vld = 2'b00;
    step();
    for (int k = 0; k < 20; k++) step();
    check("nto_wait", {psel, penable, rsp_vld}, 4'b1100);
    pready = 1'b1; prdata = 32'h66;
    step(); pready = 1'b0;
    check("nto_rsp", rsp_vld, 2'b01);
`endif

    // ---------------- randomized phase ----------------
    prst = 1'b1; step(); prst = 1'b0;
    act = '0; m_busy = 1'b0; m_pref = 1'b0; m_due = 1'b0; m_k = 0;
    m_oh = '0; m_rdata = '0; m_err = 1'b0;
    cur = '{req: 1'b0, addr: '0, write: 1'b0, wdata: '0};
    for (int c = 0; c < 3000; c++) begin
      if (m_due) begin
        check("rnd_rsp", rsp_vld, m_oh);
        check("rnd_rdata", rsp_rdata, m_rdata);
        check("rnd_err", rsp_err, m_err);
      end else begin
        check("rnd_norsp", rsp_vld, 2'b00);
      end
      m_due = 1'b0;

      for (int r = 0; r < 2; r++) begin
        if (!act[r] && $urandom_range(0, 3) == 0) begin
          act[r]       = 1'b1;
          req_addr[r]  = {8'($urandom), $urandom};
          req_write[r] = 1'($urandom);
          req_wdata[r] = $urandom;
        end else if (act[r] && $urandom_range(0, 15) == 0) begin
          act[r] = 1'b0;
        end
      end
      req_vld = act;

      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      if (m_busy && m_k >= 2) begin
        check("rnd_access", {psel, penable, busy}, 3'b111);
        check("rnd_paddr", paddr, cur.addr);
        check("rnd_pwrite", pwrite, cur.write);
        check("rnd_pwdata", pwdata, cur.wdata);
        if ($urandom_range(0, 1) == 1 || m_k == 5) begin
          pready  = 1'b1;
          pslverr = 1'($urandom);
        end
      end else if (m_busy) begin
        check("rnd_setup", {psel, penable, busy}, 3'b101);
        check("rnd_setup_paddr", paddr, cur.addr);
      end else begin
        check("rnd_idle", {psel, penable, busy}, 3'b000);
      end
      #1;

      exp_rdy = 2'b00;
      if (!m_busy && act != 2'b00) begin
        g = (act == 2'b11) ? m_pref : act[1];
        exp_rdy = g ? 2'b10 : 2'b01;
        cur = '{req: g, addr: req_addr[g], write: req_write[g], wdata: req_wdata[g]};
        act[g] = 1'b0;
        m_pref = ~g;
        m_busy = 1'b1;
        m_k    = 0;
      end
      check("rnd_rdy", req_rdy, exp_rdy);

      if (m_busy && m_k >= 2 && pready) begin
        m_due   = 1'b1;
        m_oh    = cur.req ? 2'b10 : 2'b01;
        m_rdata = cur.write ? 32'h0 : prdata;
        m_err   = pslverr;
        m_busy  = 1'b0;
      end
      step();
      if (m_busy) m_k++;
    end
    req_vld = 2'b00; pready = 1'b0;
    #1;
    if (m_due) check("rnd_final_rsp", rsp_vld, m_oh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
